// File: rtl/nv_nvdla_cmac_csb_slave_pkg.sv
// CMAC CSB slave shared definitions: request field map,
// response type codes, register offsets and group limits.
package nv_nvdla_cmac_csb_slave_pkg;

  localparam int REQ_W  = 63;
  localparam int RESP_W = 34;

  localparam int ADDR_LSB    = 0;
  localparam int ADDR_MSB    = 21;
  localparam int WDAT_LSB    = 22;
  localparam int WDAT_MSB    = 53;
  localparam int WRITE_BIT   = 54;
  localparam int NPOSTED_BIT = 55;
  localparam int SRCPRIV_BIT = 56;
  localparam int WRBE_LSB    = 57;
  localparam int WRBE_MSB    = 60;
  localparam int LEVEL_LSB   = 61;
  localparam int LEVEL_MSB   = 62;

  localparam logic RESP_TYPE_RD = 1'b0;
  localparam logic RESP_TYPE_WR = 1'b1;

  localparam logic [9:0] OFF_S_STATUS    = 10'h000;
  localparam logic [9:0] OFF_S_POINTER   = 10'h001;
  localparam logic [9:0] OFF_D_OP_ENABLE = 10'h002;
  localparam logic [9:0] OFF_D_CFG       = 10'h003;

  localparam int NDREG_MAX = 16;

  typedef struct packed {
    logic [1:0]  level;
    logic [3:0]  wrbe;
    logic        srcpriv;
    logic        nposted;
    logic        write;
    logic [31:0] wdat;
    logic [21:0] addr;
  } req_t;

  function automatic logic [31:0] be2mask(
    input logic [3:0] be
  );
    return {{8{be[3]}}, {8{be[2]}},
            {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/nv_nvdla_cmac_csb_slave_if.sv
// CSB request/response bundle between csb master and CMAC.
// master drives req_pvld/req_pd; slave drives prdy and resp.
interface nv_nvdla_cmac_csb_slave_if;

  logic csb2cmac_req_pvld;
  logic csb2cmac_req_prdy;
  logic [nv_nvdla_cmac_csb_slave_pkg::REQ_W-1:0]
        csb2cmac_req_pd;
  logic cmac2csb_resp_valid;
  logic [nv_nvdla_cmac_csb_slave_pkg::RESP_W-1:0]
        cmac2csb_resp_pd;

  modport master (
    output csb2cmac_req_pvld,
    output csb2cmac_req_pd,
    input  csb2cmac_req_prdy,
    input  cmac2csb_resp_valid,
    input  cmac2csb_resp_pd
  );

  modport slave (
    input  csb2cmac_req_pvld,
    input  csb2cmac_req_pd,
    output csb2cmac_req_prdy,
    output cmac2csb_resp_valid,
    output cmac2csb_resp_pd
  );

endinterface

// File: rtl/nv_nvdla_cmac_csb_dual_group.sv
// One ping-pong register group: op_en plus NDREG data regs.
// Ports: cfg write strobe/index/data/mask, op set, op clear.
module nv_nvdla_cmac_csb_dual_group
  import nv_nvdla_cmac_csb_slave_pkg::*;
#(
  parameter int NDREG = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_we,
  input  logic [3:0]         cfg_idx,
  input  logic [31:0]        wdat,
  input  logic [31:0]        wmask,
  input  logic               op_set,
  input  logic               op_clr,
  output logic               op_en,
  output logic [32*NDREG-1:0] cfg
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_en <= 1'b0;
      cfg   <= '0;
    end else begin
      // set wins: a same-cycle set was already
      // qualified against the post-clear op_en
      if (op_set)
        op_en <= 1'b1;
      else if (op_clr)
        op_en <= 1'b0;
      for (int k = 0; k < NDREG; k++) begin
        if (cfg_we && cfg_idx == 4'(k))
          cfg[32*k +: 32] <=
            (cfg[32*k +: 32] & ~wmask) |
            (wdat & wmask);
      end
    end
  end

endmodule

// File: rtl/nv_nvdla_cmac_csb_slave.sv
// CMAC CSB register responder: pointers, decode, response reg.
// Ports: csb slave modport, dp_op_en/dp_cfg/dp_done. Macro CMAC_CSB_ERR_RESP_EN.
module nv_nvdla_cmac_csb_slave
  import nv_nvdla_cmac_csb_slave_pkg::*;
#(
  parameter int NDREG = 4
) (
  input  logic                nvdla_core_clk,
  input  logic                nvdla_core_rstn,
  nv_nvdla_cmac_csb_slave_if.slave csb,
  output logic                dp_op_en,
  output logic [32*NDREG-1:0] dp_cfg,
  input  logic                dp_done
);

  req_t        req;
  logic [9:0]  off;
  logic [3:0]  cfg_idx;
  logic [31:0] wmask;
  logic        pvld;
  logic        wr;

  logic        producer;
  logic        consumer;
  logic [1:0]  g_op;
  logic [32*NDREG-1:0] g_cfg [2];
  logic [1:0]  g_clr;
  logic [1:0]  g_set;
  logic [1:0]  g_we;

  logic is_status;
  logic is_ptr;
  logic is_op;
  logic is_cfg;
  logic unmapped;
  logic done_hit;
  logic prod_op;
  logic lock;
  logic d_we;
  logic err;
  logic [31:0] rdat;
  logic [32*NDREG-1:0] prod_cfg;

  logic        resp_valid;
  logic [33:0] resp_pd;

  logic unused_ok;

  assign req     = req_t'(csb.csb2cmac_req_pd);
  assign pvld    = csb.csb2cmac_req_pvld;
  assign off     = req.addr[9:0];
  assign cfg_idx = 4'(off - OFF_D_CFG);
  assign wmask   = be2mask(req.wrbe);
  assign wr      = pvld & req.write;

  assign unused_ok = ^{req.srcpriv, req.level,
                       req.addr[21:10]};

  assign is_status = (off == OFF_S_STATUS);
  assign is_ptr    = (off == OFF_S_POINTER);
  assign is_op     = (off == OFF_D_OP_ENABLE);
  assign is_cfg    = (off >= OFF_D_CFG) &&
                     (off < OFF_D_CFG + 10'(NDREG));
  assign unmapped  = ~(is_status | is_ptr |
                       is_op | is_cfg);

  // dp_done retires the consumer layer before the
  // request is judged against the lock
  assign done_hit = dp_done & g_op[consumer];
  assign g_clr[0] = done_hit & ~consumer;
  assign g_clr[1] = done_hit &  consumer;
  assign prod_op  = g_op[producer] & ~g_clr[producer];

  assign lock = wr & (is_op | is_cfg) & prod_op;
  assign d_we = wr & ~lock;

  for (genvar i = 0; i < 2; i++) begin : g_grp
    assign g_set[i] = d_we & is_op & req.wdat[0] &
                      req.wrbe[0] & (producer == 1'(i));
    assign g_we[i]  = d_we & is_cfg &
                      (producer == 1'(i));

    nv_nvdla_cmac_csb_dual_group #(
      .NDREG (NDREG)
    ) u_grp (
      .clk     (nvdla_core_clk),
      .rst_n   (nvdla_core_rstn),
      .cfg_we  (g_we[i]),
      .cfg_idx (cfg_idx),
      .wdat    (req.wdat),
      .wmask   (wmask),
      .op_set  (g_set[i]),
      .op_clr  (g_clr[i]),
      .op_en   (g_op[i]),
      .cfg     (g_cfg[i])
    );
  end

  assign prod_cfg = g_cfg[producer];

  always_comb begin
    rdat = 32'h0;
    unique case (1'b1)
      is_status: begin
        rdat[0]  = g_op[0];
        rdat[16] = g_op[1];
      end
      is_ptr: begin
        rdat[0]  = producer;
        rdat[16] = consumer;
      end
      is_op: begin
        rdat[0] = g_op[producer];
      end
      is_cfg: begin
        for (int k = 0; k < NDREG; k++)
          if (cfg_idx == 4'(k))
            rdat = prod_cfg[32*k +: 32];
      end
      default: rdat = 32'h0;
    endcase
  end

`ifdef CMAC_CSB_ERR_RESP_EN
  assign err = unmapped | lock |
               (req.write & is_status);
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge nvdla_core_clk or
              negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      producer   <= 1'b0;
      consumer   <= 1'b0;
      resp_valid <= 1'b0;
      resp_pd    <= '0;
    end else begin
      if (wr && is_ptr && req.wrbe[0])
        producer <= req.wdat[0];
      if (done_hit)
        consumer <= ~consumer;
      resp_valid <= pvld &
                    (~req.write | req.nposted);
      if (pvld)
        resp_pd <= {req.write ? RESP_TYPE_WR
                              : RESP_TYPE_RD,
                    err,
                    req.write ? 32'h0 : rdat};
    end
  end

  assign csb.csb2cmac_req_prdy   = 1'b1;
  assign csb.cmac2csb_resp_valid = resp_valid;
  assign csb.cmac2csb_resp_pd    = resp_pd;
  assign dp_op_en = g_op[consumer];
  assign dp_cfg   = g_cfg[consumer];

endmodule

// File: tb/tb_nv_nvdla_cmac_csb_slave.sv
// Scoreboard bench for nv_nvdla_cmac_csb_slave (NDREG=4).
// Driver queues expected responses; negedge monitor checks them.
module tb_nv_nvdla_cmac_csb_slave;
  import nv_nvdla_cmac_csb_slave_pkg::*;

`ifdef CMAC_CSB_ERR_RESP_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dp_done;
  logic dp_op_en;
  logic [127:0] dp_cfg;

  always #5 clk = ~clk;

  nv_nvdla_cmac_csb_slave_if bus ();

  nv_nvdla_cmac_csb_slave #(.NDREG(4)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .csb             (bus.slave),
    .dp_op_en        (dp_op_en),
    .dp_cfg          (dp_cfg),
    .dp_done         (dp_done)
  );

  typedef struct {
    int          due;
    logic [33:0] pd;
  } exp_t;

  exp_t q[$];
  int cyc = 0;
  int tests = 0;
  int fails = 0;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0 && q[0].due < cyc) begin
      tests++;
      fails++;
      $display("FAIL resp_missing due=%0d now=%0d want %h",
               q[0].due, cyc, q[0].pd);
      void'(q.pop_front());
    end
    if (bus.cmac2csb_resp_valid) begin
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL resp_unexpected cyc=%0d got %h",
                 cyc, bus.cmac2csb_resp_pd);
      end else begin
        e = q.pop_front();
        if (e.due != cyc ||
            bus.cmac2csb_resp_pd !== e.pd) begin
          fails++;
          $display("FAIL resp cyc=%0d due=%0d got %h want %h",
                   cyc, e.due, bus.cmac2csb_resp_pd, e.pd);
        end
      end
    end
  end

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask

  task automatic req(input logic [21:0] a,
                     input logic [31:0] d,
                     input logic w,
                     input logic np,
                     input logic [3:0] be,
                     input logic [33:0] exp);
    bus.csb2cmac_req_pd =
      {2'b00, be, 1'b0, np, w, d, a};
    bus.csb2cmac_req_pvld = 1'b1;
    if (!w || np) q.push_back('{cyc + 1, exp});
    @(posedge clk);
    #1;
    bus.csb2cmac_req_pvld = 1'b0;
  endtask

  task automatic rd(input logic [21:0] a,
                    input logic [31:0] v,
                    input logic e);
    req(a, 32'h0, 1'b0, 1'b0, 4'h0, {RESP_TYPE_RD, e, v});
  endtask

  task automatic wr(input logic [21:0] a,
                    input logic [31:0] d,
                    input logic np,
                    input logic [3:0] be,
                    input logic e);
    req(a, d, 1'b1, np, be, {RESP_TYPE_WR, e, 32'h0});
  endtask

  task automatic done_pulse();
    dp_done = 1'b1;
    @(posedge clk);
    #1;
    dp_done = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.csb2cmac_req_pvld = 1'b0;
    bus.csb2cmac_req_pd   = '0;
    dp_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    chk("rst_op_en", {127'h0, dp_op_en}, 128'h0);
    chk("rst_cfg", dp_cfg, 128'h0);
    chk("prdy", {127'h0, bus.csb2cmac_req_prdy}, 128'h1);

    rd(22'h001, 32'h0, 1'b0);
    rd(22'h003, 32'h0, 1'b0);

    wr(22'h003, 32'hA5A5_1234, 1'b1, 4'b0101, 1'b0);
    rd(22'h003, 32'h00A5_0034, 1'b0);

    wr(22'h004, 32'hDEAD_BEEF, 1'b0, 4'hF, 1'b0);
    rd(22'h004, 32'hDEAD_BEEF, 1'b0);

    wr(22'h002, 32'h1, 1'b1, 4'h1, 1'b0);
    chk("op_en_g0", {127'h0, dp_op_en}, 128'h1);
    chk("cfg_g0", dp_cfg,
        {64'h0, 32'hDEAD_BEEF, 32'h00A5_0034});
    rd(22'h000, 32'h1, 1'b0);
    rd(22'h002, 32'h1, 1'b0);

    wr(22'h001, 32'h1, 1'b1, 4'h1, 1'b0);
    wr(22'h003, 32'h1111_2222, 1'b1, 4'hF, 1'b0);
    chk("cfg_still_g0", dp_cfg[31:0], 128'h00A5_0034);
    rd(22'h003, 32'h1111_2222, 1'b0);
    rd(22'h001, 32'h0000_0001, 1'b0);

    done_pulse();
    chk("handoff_op_en", {127'h0, dp_op_en}, 128'h0);
    chk("handoff_cfg", dp_cfg[31:0], 128'h1111_2222);
    rd(22'h001, 32'h0001_0001, 1'b0);
    rd(22'h000, 32'h0, 1'b0);

    wr(22'h002, 32'h1, 1'b1, 4'h1, 1'b0);
    chk("op_en_g1", {127'h0, dp_op_en}, 128'h1);
    wr(22'h003, 32'h3333_4444, 1'b1, 4'hF, ERR);
    rd(22'h003, 32'h1111_2222, 1'b0);

    dp_done = 1'b1;
    wr(22'h003, 32'h5555_6666, 1'b1, 4'hF, 1'b0);
    dp_done = 1'b0;
    rd(22'h003, 32'h5555_6666, 1'b0);
    chk("conflict_op_en", {127'h0, dp_op_en}, 128'h0);
    chk("conflict_cfg", dp_cfg,
        {64'h0, 32'hDEAD_BEEF, 32'h00A5_0034});
    rd(22'h002, 32'h0, 1'b0);

    done_pulse();
    rd(22'h001, 32'h0000_0001, 1'b0);

    wr(22'h004, 32'hFFFF_FFFF, 1'b1, 4'h0, 1'b0);
    rd(22'h004, 32'h0, 1'b0);
    wr(22'h000, 32'hFFFF_FFFF, 1'b1, 4'hF, ERR);
    wr(22'h010, 32'h1234_5678, 1'b1, 4'hF, ERR);
    rd(22'h403, 32'h5555_6666, 1'b0);

    rd(22'h3FF, 32'h0, ERR);
    rd(22'h000, 32'h0, 1'b0);
    rd(22'h001, 32'h0000_0001, 1'b0);

    wr(22'h001, 32'h0, 1'b1, 4'h1, 1'b0);
    wr(22'h002, 32'h1, 1'b0, 4'h1, 1'b0);
    chk("pre_rst_op_en", {127'h0, dp_op_en}, 128'h1);
    rd(22'h001, 32'h0, 1'b0);
    rst_n = 1'b0;
    q.delete();
    bus.csb2cmac_req_pd = {2'b00, 4'h0, 3'b000,
                           32'h0, 22'h001};
    bus.csb2cmac_req_pvld = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.csb2cmac_req_pvld = 1'b0;
    chk("inrst_op_en", {127'h0, dp_op_en}, 128'h0);
    chk("inrst_cfg", dp_cfg, 128'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rd(22'h001, 32'h0, 1'b0);
    rd(22'h000, 32'h0, 1'b0);
    rd(22'h003, 32'h0, 1'b0);
    rd(22'h002, 32'h0, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
